// File: rtl/instruction_queue.sv
// instruction_queue: instruction FIFO prefetch buffer with PC tags and MIPS field decode (optional IQ_SIGN_EXT_EN adds imm_ext)
module instruction_queue #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [5:0]          q31_26,
    output logic [4:0]          q25_21,
    output logic [4:0]          q20_16,
    output logic [4:0]          q15_11,
    output logic [4:0]          q10_6,
    output logic [5:0]          q5_0,
    output logic [15:0]         q15_0,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                empty
`ifdef IQ_SIGN_EXT_EN
    ,
    output logic [31:0]         imm_ext
`endif
);
    logic [31:0]         r_instr [DEPTH];
    logic [PC_WIDTH-1:0] r_pc    [DEPTH];
    logic [ADDR_W-1:0]   r_wr;
    logic [ADDR_W-1:0]   r_rd;
    logic [ADDR_W:0]     r_count;
    logic                w_push;
    logic                w_pop;
    assign full      = r_count == (ADDR_W+1)'(DEPTH);
    assign empty     = r_count == '0;
    assign count     = r_count;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    // storage write; contents are not reset because outputs are gated when empty
    always_ff @(posedge clk) begin
        if (w_push && !reset && !flush) begin
            r_instr[r_wr] <= in_instr;
            r_pc[r_wr]    <= in_pc;
        end
    end
    // pointers and occupancy; reset and flush both drop any same-cycle push/pop
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
        end
    end
    // head presentation, forced to zero when empty so no stale entry leaks out
    always_comb begin
        out_instr = empty ? 32'd0 : r_instr[r_rd];
        out_pc    = empty ? '0 : r_pc[r_rd];
    end
    assign q31_26 = out_instr[31:26];
    assign q25_21 = out_instr[25:21];
    assign q20_16 = out_instr[20:16];
    assign q15_11 = out_instr[15:11];
    assign q10_6  = out_instr[10:6];
    assign q5_0   = out_instr[5:0];
    assign q15_0  = out_instr[15:0];
`ifdef IQ_SIGN_EXT_EN
    assign imm_ext = {{16{out_instr[15]}}, out_instr[15:0]};
`endif
endmodule

// File: doc/instruction_queue.md
# instruction_queue

Parametrised instruction register with a FIFO prefetch buffer for the multicycle CPU. It sits between instruction memory and the control unit. It holds up to DEPTH fetched instructions, each tagged with its PC, behind valid/ready handshakes. The head entry is presented both as the raw word and pre-split into MIPS fields. It also provides flush for branch/jump redirects.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2
- ADDR_W, 2, log2(DEPTH)
- PC_WIDTH, 32, width of the PC tag stored per entry

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all entries
- in_valid  in  1  producer offers in_instr/in_pc
- in_ready  out  1  queue accepts (= !full)
- in_instr  in  32  fetched instruction word
- in_pc  in  PC_WIDTH  PC of in_instr
- out_valid  out  1  head entry valid (= !empty)
- out_ready  in  1  consumer takes head entry
- out_instr  out  32  head instruction
- out_pc  out  PC_WIDTH  head PC
- q31_26  out  6  opcode field of head
- q25_21  out  5  rs field
- q20_16  out  5  rt field
- q15_11  out  5  rd field
- q10_6  out  5  shamt field
- q5_0  out  6  funct field
- q15_0  out  16  immediate field
- count  out  ADDR_W+1  occupancy 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Event definitions:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
- Storage is a circular buffer.
  - wr_ptr and rd_ptr are ADDR_W bits wide and wrap naturally at DEPTH.
  - count is tracked separately.
- Push: write {in_instr, in_pc} at wr_ptr, then increment wr_ptr.
- Pop: increment rd_ptr.
- count update: push only → +1; pop only → -1; both or neither → unchanged.
- Outputs are combinational from the registered storage at rd_ptr.
- All field outputs are slices of out_instr.
- When empty, out_instr, out_pc and all field outputs read 0, never stale data.
- Priority, highest first: reset > flush > push/pop.
  - flush clears pointers and count.
  - A push or pop in the same cycle as flush is discarded.
- Full: in_ready=0, so a simultaneous push and pop cannot occur. There is no pass-through when full.
- Empty: out_valid=0. A pushed word is never forwarded in the same cycle (no bypass).
- Storage contents need not reset; output gating makes every output determinate.
- in_instr/in_pc are sampled only on a push edge.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, full=0, empty=1, count=0
  - out_instr, out_pc and all fields = 0
- Push at edge N: the entry is visible at the head (if the queue was empty) and count is updated from just after edge N.
- Push-to-out latency is 1 cycle.
- Throughput is one push and one pop per cycle.
- in_ready and out_valid depend only on registered count. There are no combinational in→out handshake paths.
- Reset or flush asserted in cycle N: empty from just after edge N.

## Configuration
- IQ_SIGN_EXT_EN defined:
  - Adds output imm_ext [31:0] = sign-extended q15_0.
  - imm_ext is 0 when empty.
- IQ_SIGN_EXT_EN undefined:
  - imm_ext port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset:
  - Stimulus: assert reset for 1 cycle with in_valid=1.
  - Response: count=0, empty=1, in_ready=1, out_valid=0, all field outputs 0.
- Single push and decode:
  - Stimulus: push in_instr=32'hAF31AF31, in_pc=32'h100, out_ready=0.
  - Response next cycle: out_valid=1, count=1.
  - Fields: q31_26=6'h2B, q25_21=5'h19, q20_16=5'h11, q15_11=5'h15, q10_6=5'h1C, q5_0=6'h31, q15_0=16'hAF31, out_pc=32'h100.
  - With IQ_SIGN_EXT_EN: imm_ext=32'hFFFFAF31.
- Fill and drain:
  - Stimulus: push 1,2,3,4 (DEPTH=4), then attempt a 5th push of 5.
  - Response: full=1, in_ready=0, and 5 is not stored.
  - Pop 4 times: values read 1,2,3,4 in order, then empty=1 and out_instr=0.
- Simultaneous push/pop and wrap:
  - Stimulus: hold count at 2 while pushing and popping every cycle for 8 cycles.
  - Response: count stays 2 throughout; popped data equals the pushed sequence, delayed by 2 entries, across pointer wrap.
- Flush with concurrent push:
  - Stimulus: count=3, assert flush together with a push of 32'h12345678.
  - Response next cycle: count=0, out_valid=0; 32'h12345678 never appears at the head.
- Reset mid-stream:
  - Stimulus: count=2, assert reset together with both push and pop.
  - Response next cycle: empty=1, count=0.
  - A subsequent push of 32'h0 appears after 1 cycle with q31_26=0.
